// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: load-use stalls,
// taken-branch IF/ID squash, and a fixed-latency mult/div sequencer.
module hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int REG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch_taken,
    input  logic             id_md_start,
    input  logic             id_reads_hilo,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             md_go,
    output logic             md_busy,
    output logic             md_done
);

    localparam int CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic lu;
    logic mdh;
    logic hold;
    logic busy_int;
    logic go_int;
    logic done_int;

    // $zero is never a real producer, so a load to r0 cannot create a hazard.
    assign lu = ex_memread && (ex_rd != '0) &&
                ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign busy_int = (state_reg == BUSY);
    assign mdh      = busy_int && (id_reads_hilo || id_md_start);
    assign hold     = lu || mdh;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        go_int     = 1'b0;
        done_int   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (id_md_start && !lu) begin
                    go_int     = 1'b1;
                    state_next = BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    done_int   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Reset masks every output, including the purely combinational hazard terms.
    assign stall_pc   = !rst && hold;
    assign stall_ifid = !rst && hold;
    assign flush_idex = !rst && hold;
    assign flush_ifid = !rst && id_branch_taken && !hold;
    assign md_go      = !rst && go_int;
    assign md_busy    = !rst && busy_int;
    assign md_done    = !rst && done_int;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step drives one cycle of ID/EX inputs and
// queues the expected output vector, which is popped and checked mid-cycle.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_branch_taken;
    logic       id_md_start;
    logic       id_reads_hilo;
    logic       ex_memread;
    logic [4:0] ex_rd;
    logic       stall_pc;
    logic       stall_ifid;
    logic       flush_ifid;
    logic       flush_idex;
    logic       md_go;
    logic       md_busy;
    logic       md_done;

    hazard_ctrl #(
        .MD_LATENCY(4),
        .REG_W     (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .id_branch_taken(id_branch_taken),
        .id_md_start    (id_md_start),
        .id_reads_hilo  (id_reads_hilo),
        .ex_memread     (ex_memread),
        .ex_rd          (ex_rd),
        .stall_pc       (stall_pc),
        .stall_ifid     (stall_ifid),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .md_go          (md_go),
        .md_busy        (md_busy),
        .md_done        (md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Expected vector order: {stall_pc, stall_ifid, flush_ifid, flush_idex, md_go, md_busy, md_done}
    localparam logic [6:0] NONE  = 7'b0000000;
    localparam logic [6:0] STALL = 7'b1101000;
    localparam logic [6:0] FLUSH = 7'b0010000;
    localparam logic [6:0] GO    = 7'b0000100;
    localparam logic [6:0] BSY   = 7'b0000010;
    localparam logic [6:0] BSTL  = 7'b1101010;
    localparam logic [6:0] BDONE = 7'b1101011;
    localparam logic [6:0] DONE  = 7'b0000011;

    task automatic step(input string tag, input logic r,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic br, input logic mds, input logic hilo,
                        input logic mrd, input logic [4:0] rd, input logic [6:0] exp);
        exp_t e;
        exp_t got;
        logic [6:0] obs;
        @(posedge clk);
        #1;
        rst             = r;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = urt;
        id_branch_taken = br;
        id_md_start     = mds;
        id_reads_hilo   = hilo;
        ex_memread      = mrd;
        ex_rd           = rd;
        e.tag = tag;
        e.exp = exp;
        q.push_back(e);
        @(negedge clk);
        got = q.pop_front();
        obs = {stall_pc, stall_ifid, flush_ifid, flush_idex, md_go, md_busy, md_done};
        n_checks++;
        assert (obs === got.exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", got.tag, obs, got.exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_branch_taken = 1'b0;
        id_md_start = 1'b0; id_reads_hilo = 1'b0; ex_memread = 1'b0; ex_rd = '0;

        //     tag              rst rs  rt  urt br  mds hilo mrd rd  expected
        step("reset_masks",     1, 8,  0,  0,  1,  1,  0,  1,  8,  NONE);
        step("reset_quiet",     1, 0,  0,  0,  0,  0,  0,  0,  0,  NONE);
        step("idle",            0, 0,  0,  0,  0,  0,  0,  0,  0,  NONE);
        step("lu_rs",           0, 8,  3,  0,  0,  0,  0,  1,  8,  STALL);
        step("lu_cleared",      0, 8,  3,  0,  0,  0,  0,  0,  8,  NONE);
        step("rt_ungated",      0, 1,  9,  0,  0,  0,  0,  1,  9,  NONE);
        step("rt_gated",        0, 1,  9,  1,  0,  0,  0,  1,  9,  STALL);
        step("zero_reg",        0, 0,  0,  1,  0,  0,  0,  1,  0,  NONE);
        step("branch",          0, 2,  3,  1,  1,  0,  0,  0,  0,  FLUSH);
        step("branch_lu",       0, 8,  3,  1,  1,  0,  0,  1,  8,  STALL);
        step("branch_retry",    0, 8,  3,  1,  1,  0,  0,  0,  8,  FLUSH);
        step("md_blocked_lu",   0, 8,  3,  1,  0,  1,  0,  1,  8,  STALL);
        // mult then mfhi
        step("mult_go",         0, 4,  5,  1,  0,  1,  0,  0,  0,  GO);
        step("mfhi_t1",         0, 0,  0,  0,  0,  0,  1,  0,  0,  BSTL);
        step("mfhi_t2",         0, 0,  0,  0,  0,  0,  1,  0,  0,  BSTL);
        step("mfhi_t3",         0, 0,  0,  0,  0,  0,  1,  0,  0,  BSTL);
        step("mfhi_t4_done",    0, 0,  0,  0,  0,  0,  1,  0,  0,  BDONE);
        step("mfhi_t5_go",      0, 0,  0,  0,  0,  0,  1,  0,  0,  NONE);
        // back-to-back div
        step("div1_go",         0, 4,  5,  1,  0,  1,  0,  0,  0,  GO);
        step("div2_held_t1",    0, 6,  7,  1,  0,  1,  0,  0,  0,  BSTL);
        step("div2_held_t2",    0, 6,  7,  1,  0,  1,  0,  0,  0,  BSTL);
        step("div2_held_t3",    0, 6,  7,  1,  0,  1,  0,  0,  0,  BSTL);
        step("div2_held_t4",    0, 6,  7,  1,  0,  1,  0,  0,  0,  BDONE);
        step("div2_go_t5",      0, 6,  7,  1,  0,  1,  0,  0,  0,  GO);
        step("div2_busy",       0, 0,  0,  0,  0,  0,  0,  0,  0,  BSY);
        // reset mid-operation aborts it without md_done
        step("rst_mid_busy",    1, 0,  0,  0,  1,  1,  1,  0,  0,  NONE);
        step("after_rst_idle",  0, 0,  0,  0,  0,  0,  0,  0,  0,  NONE);
        step("no_done_1",       0, 0,  0,  0,  0,  0,  0,  0,  0,  NONE);
        step("no_done_2",       0, 0,  0,  0,  0,  0,  0,  0,  0,  NONE);
        step("no_done_3",       0, 0,  0,  0,  0,  0,  0,  0,  0,  NONE);
        // fresh operation after reset; lu+mdh together and branch under stall
        step("md3_go",          0, 4,  5,  1,  0,  1,  0,  0,  0,  GO);
        step("md3_busy1",       0, 0,  0,  0,  0,  0,  0,  0,  0,  BSY);
        step("md3_lu_and_mdh",  0, 8,  0,  0,  0,  0,  1,  1,  8,  BSTL);
        step("md3_branch_mdh",  0, 0,  0,  0,  1,  0,  1,  0,  0,  BSTL);
        step("md3_done",        0, 0,  0,  0,  0,  0,  0,  0,  0,  DONE);
        step("md3_idle",        0, 0,  0,  0,  0,  0,  0,  0,  0,  NONE);
        step("idle_branch",     0, 0,  0,  0,  1,  0,  1,  0,  0,  FLUSH);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
